memory_array: RTL and testbench

Parametrised, clocked successor to the 8×8 latch memory unit: a DEPTH×DATA_W register array with a single request port, registered read data, a per-word written mask, and a multi-cycle bulk-clear mode driven by an internal state machine. It sits between the bus controller and the datapath as the general-purpose scratch store. Any 2^ADDR_W depth and any data width are supported without code changes.

---
 rtl/memory_array.sv | 123 ++++++++++++
 tb/tb_memory_array.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_array.sv
`default_nettype none
// ============================================================================
// Module   : memory_array
// Purpose  : DEPTH x DATA_W scratch register array with registered reads,
//            per-word written mask and a multi-cycle bulk-clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module memory_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    select,
    input  logic [1:0]              op,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_W-1:0]       in_bus,
    output logic                    ready,
    output logic [DATA_W-1:0]       out_bus,
    output logic                    out_valid,
    output logic                    err,
    output logic [(1<<ADDR_W)-1:0]  written
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0]        C_OP_READ  = 2'b00;
    localparam logic [1:0]        C_OP_WRITE = 2'b01;
    localparam logic [1:0]        C_OP_CLEAR = 2'b10;
    localparam logic [ADDR_W-1:0] C_LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clear_idx_q, clear_idx_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]    written_q, written_d;
    logic [DATA_W-1:0]   out_bus_q, out_bus_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        mem_d       = mem_q;
        written_d   = written_q;
        out_bus_d   = out_bus_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (select) begin
                    case (op)
                        C_OP_READ: begin
                            out_bus_d   = mem_q[address];
                            out_valid_d = 1'b1;
                            err_d       = ~written_q[address];
                        end
                        C_OP_WRITE: begin
                            mem_d[address]     = in_bus;
                            written_d[address] = 1'b1;
                        end
                        C_OP_CLEAR: begin
                            state_d     = S_CLEAR;
                            clear_idx_d = '0;
                            written_d   = '0;
                        end
                        default: begin
                            // Reserved opcode: respond with an error, keep last read data.
                            out_valid_d = 1'b1;
                            err_d       = 1'b1;
                        end
                    endcase
                end
            end
            S_CLEAR: begin
                mem_d[clear_idx_q] = '0;
                clear_idx_d        = clear_idx_q + 1'b1;
                if (clear_idx_q == C_LAST_IDX) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clear_idx_q <= '0;
            written_q   <= '0;
            out_bus_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            written_q   <= written_d;
            out_bus_q   <= out_bus_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign out_bus   = out_bus_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign written   = written_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_array
// Purpose  : Scoreboard bench for memory_array at 8x8 and a 32x16 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_array;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8 x 8 instance
    logic        rst_a, sel_a, rdy_a, vld_a, err_a;
    logic [1:0]  op_a;
    logic [2:0]  addr_a;
    logic [7:0]  din_a, dout_a, wr_a;

    // 32 x 16 instance
    logic        rst_b, sel_b, rdy_b, vld_b, err_b;
    logic [1:0]  op_b;
    logic [4:0]  addr_b;
    logic [15:0] din_b, dout_b;
    logic [31:0] wr_b;

    memory_array #(.DATA_W(8), .ADDR_W(3)) u_dut_a (
        .clk(clk), .rst(rst_a), .select(sel_a), .op(op_a), .address(addr_a),
        .in_bus(din_a), .ready(rdy_a), .out_bus(dout_a), .out_valid(vld_a),
        .err(err_a), .written(wr_a)
    );

    memory_array #(.DATA_W(16), .ADDR_W(5)) u_dut_b (
        .clk(clk), .rst(rst_b), .select(sel_b), .op(op_b), .address(addr_b),
        .in_bus(din_b), .ready(rdy_b), .out_bus(dout_b), .out_valid(vld_b),
        .err(err_b), .written(wr_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_mem [8];
    logic [7:0] m_wr;
    logic [7:0] m_last;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_wr   = 8'h00;
        m_last = 8'h00;
    endtask

    // Drives one request on instance A and records the expected response.
    task automatic req_a(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        sel_a = 1'b1; op_a = o; addr_a = a; din_a = d;
        case (o)
            OP_RD: begin
                sb_q.push_back(exp_t'({m_mem[a], ~m_wr[a]}));
                m_last = m_mem[a];
            end
            OP_WR: begin
                m_mem[a] = d;
                m_wr[a]  = 1'b1;
            end
            OP_CLR: begin
                for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
                m_wr = 8'h00;
            end
            default: sb_q.push_back(exp_t'({m_last, 1'b1}));
        endcase
        @(posedge clk);
        #1 sel_a = 1'b0;
    endtask

    task automatic req_b(input logic [1:0] o, input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        sel_b = 1'b1; op_b = o; addr_b = a; din_b = d;
        @(posedge clk);
        #1 sel_b = 1'b0;
    endtask

    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (!rst_a) begin
            if (vld_a) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_valid", 64'(vld_a), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    check_val("rd_data", 64'(dout_a), 64'(e.data));
                    check_val("rd_err", 64'(err_a), 64'(e.err));
                end
            end else if (err_a) begin
                check_val("err_without_valid", 64'(err_a), 64'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cnt;
        bit  done;
        rst_a = 1'b1; sel_a = 1'b0; op_a = OP_RD; addr_a = '0; din_a = '0;
        rst_b = 1'b1; sel_b = 1'b0; op_b = OP_RD; addr_b = '0; din_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", 64'(rdy_a), 64'(1));
        check_val("rst_out_bus", 64'(dout_a), 64'(0));
        check_val("rst_valid", 64'(vld_a), 64'(0));
        check_val("rst_err", 64'(err_a), 64'(0));
        check_val("rst_written", 64'(wr_a), 64'(0));
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Unwritten read, then write/readback
        req_a(OP_RD, 3'd5, 8'h00);
        req_a(OP_WR, 3'd3, 8'hA5);
        req_a(OP_RD, 3'd3, 8'h00);
        @(negedge clk);
        check_val("written_after_wr3", 64'(wr_a), 64'(8'h08));

        // Back-to-back reads
        req_a(OP_WR, 3'd0, 8'h11);
        req_a(OP_WR, 3'd7, 8'h22);
        req_a(OP_RD, 3'd0, 8'h00);
        req_a(OP_RD, 3'd7, 8'h00);
        req_a(OP_RD, 3'd0, 8'h00);
        @(negedge clk);
        check_val("b2b_valid_last", 64'(vld_a), 64'(1));
        @(negedge clk);
        check_val("b2b_valid_drop", 64'(vld_a), 64'(0));

        // Asynchronous reset mid-cycle while a read response is showing
        req_a(OP_WR, 3'd5, 8'h77);
        req_a(OP_RD, 3'd5, 8'h00);
        @(negedge clk);
        #1 rst_a = 1'b1;
        #1;
        check_val("async_rst_valid", 64'(vld_a), 64'(0));
        check_val("async_rst_out_bus", 64'(dout_a), 64'(0));
        check_val("async_rst_written", 64'(wr_a), 64'(0));
        check_val("async_rst_ready", 64'(rdy_a), 64'(1));
        model_reset();
        @(negedge clk);
        #1 rst_a = 1'b0;
        req_a(OP_RD, 3'd5, 8'h00);

        // Fill and bulk clear; stray requests in the window must be ignored
        for (int i = 0; i < 8; i++) req_a(OP_WR, 3'(i), 8'h30 + 8'(i));
        @(negedge clk);
        check_val("written_full", 64'(wr_a), 64'(8'hFF));
        req_a(OP_CLR, 3'd0, 8'h00);
        check_val("clr_ready_low", 64'(rdy_a), 64'(0));
        check_val("clr_written_zero", 64'(wr_a), 64'(0));
        cnt = 0; done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (rdy_a) begin
                sel_a = 1'b0;
                done  = 1'b1;
            end else begin
                cnt++;
                sel_a = 1'b1; op_a = t[0] ? OP_RD : OP_WR;
                addr_a = 3'(t); din_a = 8'hEE;
            end
        end
        sel_a = 1'b0;
        check_val("clr_done", 64'(done), 64'(1));
        check_val("clr_busy_cycles", 64'(cnt), 64'(8));
        check_val("clr_written_after", 64'(wr_a), 64'(0));
        req_a(OP_RD, 3'd0, 8'h00);
        req_a(OP_RD, 3'd4, 8'h00);
        req_a(OP_RD, 3'd7, 8'h00);

        // Reserved op keeps last read data; later write leaves it alone
        req_a(OP_WR, 3'd2, 8'h5A);
        req_a(OP_RD, 3'd2, 8'h00);
        req_a(OP_RSV, 3'd2, 8'h00);
        req_a(OP_WR, 3'd4, 8'h99);
        @(negedge clk);
        check_val("hold_after_write", 64'(dout_a), 64'(8'h5A));
        check_val("hold_no_valid", 64'(vld_a), 64'(0));

        // 32 x 16 instance
        req_b(OP_WR, 5'd31, 16'hBEEF);
        req_b(OP_RD, 5'd31, 16'h0000);
        check_val("b_rd_valid", 64'(vld_b), 64'(1));
        check_val("b_rd_data", 64'(dout_b), 64'(16'hBEEF));
        check_val("b_rd_err", 64'(err_b), 64'(0));
        req_b(OP_CLR, 5'd0, 16'h0000);
        cnt = 0; done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (rdy_b) done = 1'b1;
            else cnt++;
        end
        check_val("b_clr_busy_cycles", 64'(cnt), 64'(32));
        req_b(OP_RD, 5'd31, 16'h0000);
        check_val("b_clr_rd_data", 64'(dout_b), 64'(0));
        check_val("b_clr_rd_err", 64'(err_b), 64'(1));

        req_b(OP_WR, 5'd31, 16'hBEEF);
        req_b(OP_CLR, 5'd0, 16'h0000);
        repeat (10) @(posedge clk);
        #2;
        check_val("b_midclr_busy", 64'(rdy_b), 64'(0));
        rst_b = 1'b1;
        #1;
        check_val("b_midclr_rst_ready", 64'(rdy_b), 64'(1));
        check_val("b_midclr_rst_written", 64'(wr_b), 64'(0));
        @(negedge clk);
        rst_b = 1'b0;
        req_b(OP_RD, 5'd31, 16'h0000);
        check_val("b_post_rst_data", 64'(dout_b), 64'(0));
        check_val("b_post_rst_err", 64'(err_b), 64'(1));

        repeat (3) @(negedge clk);
        check_val("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
